pmu_dump_sequencer: RTL and testbench
=====================================

Name: pmu_dump_sequencer

Overview:
- Sits directly downstream of the 16-node loader/PMU cosimulation top and consumes its per-node PMU readout port (pmu_addr/pmu_data) and loader idle flags.
- After a traffic run, it waits for all loaders to go idle, then scans every counter address of every node's PMU.
- It serializes each 64-bit counter into a byte stream with a valid/ready handshake, for the cosimulation host or a UART bridge.

Parameters:
- NODES, 16, number of mesh nodes / PMUs scanned.
- PMU_ADDR_W, 5, width of each PMU address port.
- PMU_DATA_W, 64, counter width; must be a multiple of 8.
- NUM_COUNTERS, 8, counter addresses 0..NUM_COUNTERS-1 read per node; 1..2**PMU_ADDR_W.
- READ_LAT, 1, cycles from address change to valid pmu_data; 0..3.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle dump request.
- idle_i  in  1 x[NODES]  loader idle flags.
- pmu_addr_o  out  PMU_ADDR_W x[NODES]  counter select, same value driven to all nodes.
- pmu_data_i  in  PMU_DATA_W x[NODES]  counter values.
- m_data_o  out  8  stream byte.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- busy_o  out  1  high from accepted start until the last byte is accepted.
- done_o  out  1  one-cycle pulse after the final byte handshake.

Behaviour:
- Reset values: pmu_addr_o all 0, m_data_o 0, m_valid_o 0, busy_o 0, done_o 0, FSM in IDLE.
- Reset is asynchronous; assertion mid-dump aborts immediately. No partial frame resumes.
- start_i is accepted only in IDLE. It is ignored while busy_o=1. Accepted start sets busy_o on the next edge.
- FSM states:
  - IDLE: on start_i, go to WAIT_IDLE.
  - WAIT_IDLE: stay until AND of all idle_i = 1, sampled in one cycle. Then go to HEADER.
  - HEADER: present 0xA5 with m_valid_o=1. On handshake, set node=0, addr=0 and go to SETTLE.
  - SETTLE: drive pmu_addr_o=addr to every node. Count READ_LAT cycles. Then capture pmu_data_i[node] into a shift register and go to EMIT. With READ_LAT=0, capture happens in the same cycle SETTLE is entered.
  - EMIT: send PMU_DATA_W/8 bytes, least-significant byte first. Shift by 8 on each handshake. After the last byte:
    - if addr < NUM_COUNTERS-1: addr++ and go to SETTLE;
    - else if node < NODES-1: node++, addr=0 and go to SETTLE;
    - else go to TAIL (if the optional feature is enabled) or DONE.
  - DONE: drop busy, pulse done_o for one cycle, return to IDLE.
- Stream rules (AXI-Stream style):
  - A byte transfers when m_valid_o & m_ready_i are both high on a rising edge.
  - Once asserted, m_valid_o stays high and m_data_o stays stable until the handshake.
  - m_valid_o never depends combinationally on m_ready_i.
  - With m_ready_i held high, one byte is sent per cycle inside a word.
  - Between words there is an unavoidable gap of 1+READ_LAT cycles.
  - Back-pressure of any length stalls with no loss or duplication.
- Counters and widths: node counter is clog2(NODES) bits, addr counter is PMU_ADDR_W bits, byte counter is clog2(PMU_DATA_W/8) bits. All wrap explicitly to 0 at their limits.
- Frame length = 1 + NODES*NUM_COUNTERS*(PMU_DATA_W/8) bytes (+1 with the feature). Defaults: 1025 (1026).
- Counter data is read in the same cycle as capture. It is not frozen: counters that change after capture are not reflected.

Optional Feature:
- Macro PMU_DUMP_CHECKSUM_EN.
- Defined: state TAIL appends one byte equal to the XOR of every prior frame byte, header included. The running XOR is cleared on accepted start and updated on each handshake. TAIL then goes to DONE.
- Undefined: TAIL and the XOR register are absent; the frame ends after the last counter byte.

Decomposition:
- Package pmu_dump_pkg:
  - state enum;
  - localparam HEADER_BYTE = 8'hA5;
  - a function for the frame-length constant.
- Sub-module pmu_word_serializer: loads a PMU_DATA_W word and emits bytes over valid/ready, signalling last_byte. The FSM in pmu_dump_sequencer drives its load and watches last_byte.

Test Plan:
- All idle_i=1, m_ready_i=1, pmu_data_i[n] = {n, addr} pattern → 1025 bytes. First byte 0xA5, then bytes 0x00,0x00 (node 0, addr 0, LSB first, rest zero). Then done_o pulses once. busy_o is high for exactly the expected cycle count.
- idle_i[7]=0 for 50 cycles after start → m_valid_o stays 0 until one cycle after idle_i[7] rises, then header 0xA5.
- m_ready_i random at 30% duty → byte sequence identical to the full-rate run; m_data_o stable while valid && !ready (checked by assertion).
- start_i pulsed again at byte 200 → ignored; frame length still 1025, single done_o.
- aresetn dropped at byte 500 then released, then start → all outputs at reset values during reset; the new frame begins with 0xA5 and is complete.
- PMU_DUMP_CHECKSUM_EN defined, all counters 0 → 1026 bytes; last byte 0xA5, since the XOR of the header and all-zero data is 0xA5.

Source files
------------

// File: rtl/pmu_dump_pkg.sv
// Shared types and constants for the PMU dump sequencer.
// PMU_DUMP_CHECKSUM_EN adds the trailing XOR checksum byte (state StTail).
package pmu_dump_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StWaitIdle,
        StHeader,
        StSettle,
        StEmit,
        StDone
`ifdef PMU_DUMP_CHECKSUM_EN
        , StTail
`endif
    } dump_state_e;

    // Counter width that stays legal when the count is 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    function automatic int unsigned frame_bytes(input int unsigned nodes,
                                                input int unsigned counters,
                                                input int unsigned data_w);
        int unsigned n;
        n = 1 + nodes * counters * (data_w / 8);
`ifdef PMU_DUMP_CHECKSUM_EN
        n = n + 1;
`endif
        return n;
    endfunction

endpackage

// File: rtl/pmu_word_serializer.sv
// Loads one PMU counter word and emits it LSB byte first over valid/ready.
// Output data and valid come straight from registers, so they never depend on ready.
module pmu_word_serializer
    import pmu_dump_pkg::*;
#(
    parameter int unsigned PMU_DATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  i_load,
    input  logic [PMU_DATA_W-1:0] i_word,
    input  logic                  i_ready,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    output logic                  o_last_byte
);

    localparam int unsigned BYTES = PMU_DATA_W / 8;
    localparam int unsigned CW    = cnt_width(BYTES);

    logic [PMU_DATA_W-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_valid;
    logic                  w_last;

    assign w_last = (r_cnt == CW'(BYTES - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_shift <= r_shift >> 8;
            if (w_last) begin
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_data      = r_shift[7:0];
    assign o_valid     = r_valid;
    assign o_last_byte = r_valid & w_last;

endmodule

// File: rtl/pmu_dump_sequencer.sv
// Scans every counter of every node's PMU after the loaders go idle and streams the
// dump as a byte frame. PMU_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module pmu_dump_sequencer
    import pmu_dump_pkg::*;
#(
    parameter int unsigned NODES        = 16,
    parameter int unsigned PMU_ADDR_W   = 5,
    parameter int unsigned PMU_DATA_W   = 64,
    parameter int unsigned NUM_COUNTERS = 8,
    parameter int unsigned READ_LAT     = 1
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 start_i,
    input  logic [NODES-1:0]                     idle_i,
    output logic [NODES-1:0][PMU_ADDR_W-1:0]     pmu_addr_o,
    input  logic [NODES-1:0][PMU_DATA_W-1:0]     pmu_data_i,
    output logic [7:0]                           m_data_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int unsigned NW = cnt_width(NODES);

    dump_state_e           r_state;
    logic [NW-1:0]         r_node;
    logic [PMU_ADDR_W-1:0] r_addr;
    logic [1:0]            r_lat;
    logic                  r_ctl_valid;
    logic [7:0]            r_ctl_data;
    logic                  r_busy;
    logic                  r_done;
`ifdef PMU_DUMP_CHECKSUM_EN
    logic [7:0]            r_xor;
`endif

    logic                  w_load;
    logic [7:0]            w_ser_data;
    logic                  w_ser_valid;
    logic                  w_ser_last;
    logic                  w_last_hs;

    // Capture happens on the edge that ends SETTLE, so the word gap is 1+READ_LAT.
    assign w_load    = (r_state == StSettle) && (r_lat == 2'(READ_LAT));
    assign w_last_hs = w_ser_last & m_ready_i;

    pmu_word_serializer #(
        .PMU_DATA_W (PMU_DATA_W)
    ) u_ser (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_load      (w_load),
        .i_word      (pmu_data_i[r_node]),
        .i_ready     (m_ready_i),
        .o_data      (w_ser_data),
        .o_valid     (w_ser_valid),
        .o_last_byte (w_ser_last)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= StIdle;
            r_node      <= '0;
            r_addr      <= '0;
            r_lat       <= '0;
            r_ctl_valid <= 1'b0;
            r_ctl_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PMU_DUMP_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef PMU_DUMP_CHECKSUM_EN
            if (m_valid_o && m_ready_i) begin
                r_xor <= r_xor ^ m_data_o;
            end
`endif
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_busy  <= 1'b1;
                        r_state <= StWaitIdle;
`ifdef PMU_DUMP_CHECKSUM_EN
                        r_xor   <= '0;
`endif
                    end
                end
                StWaitIdle: begin
                    if (&idle_i) begin
                        r_ctl_valid <= 1'b1;
                        r_ctl_data  <= HEADER_BYTE;
                        r_state     <= StHeader;
                    end
                end
                StHeader: begin
                    if (m_ready_i) begin
                        r_ctl_valid <= 1'b0;
                        r_node      <= '0;
                        r_addr      <= '0;
                        r_lat       <= '0;
                        r_state     <= StSettle;
                    end
                end
                StSettle: begin
                    if (r_lat == 2'(READ_LAT)) begin
                        r_state <= StEmit;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                StEmit: begin
                    if (w_last_hs) begin
                        r_lat <= '0;
                        if (r_addr != PMU_ADDR_W'(NUM_COUNTERS - 1)) begin
                            r_addr  <= r_addr + PMU_ADDR_W'(1);
                            r_state <= StSettle;
                        end else if (r_node != NW'(NODES - 1)) begin
                            r_node  <= r_node + NW'(1);
                            r_addr  <= '0;
                            r_state <= StSettle;
                        end else begin
                            r_node <= '0;
                            r_addr <= '0;
`ifdef PMU_DUMP_CHECKSUM_EN
                            // r_xor does not yet hold the byte accepted on this edge.
                            r_ctl_valid <= 1'b1;
                            r_ctl_data  <= r_xor ^ m_data_o;
                            r_state     <= StTail;
`else
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
`endif
                        end
                    end
                end
`ifdef PMU_DUMP_CHECKSUM_EN
                StTail: begin
                    if (m_ready_i) begin
                        r_ctl_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= StDone;
                    end
                end
`endif
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        for (int n = 0; n < int'(NODES); n++) begin
            pmu_addr_o[n] = r_addr;
        end
    end

    assign m_valid_o = r_ctl_valid | w_ser_valid;
    assign m_data_o  = r_ctl_valid ? r_ctl_data : w_ser_data;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule

// File: tb/tb_pmu_dump_sequencer.sv
// Directed bench for pmu_dump_sequencer: full-rate, idle wait, back-pressure, restart,
// mid-frame reset and all-zero (checksum) frames.
module tb_pmu_dump_sequencer;
    import pmu_dump_pkg::*;

    localparam int unsigned NODES = 16;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 64;
`ifdef PMU_DUMP_CHECKSUM_EN
    localparam int unsigned EXP_LEN  = 1026;
    localparam int unsigned EXP_BUSY = 1283;
    localparam logic [7:0]  EXP_ZERO_LAST = 8'hA5;
`else
    localparam int unsigned EXP_LEN  = 1025;
    localparam int unsigned EXP_BUSY = 1282;
    localparam logic [7:0]  EXP_ZERO_LAST = 8'h00;
`endif

    logic                         aclk = 1'b0;
    logic                         aresetn;
    logic                         start_i;
    logic [NODES-1:0]             idle_i;
    logic [NODES-1:0][AW-1:0]     pmu_addr_o;
    logic [NODES-1:0][DW-1:0]     pmu_data;
    logic [7:0]                   m_data_o;
    logic                         m_valid_o;
    logic                         m_ready_i;
    logic                         busy_o;
    logic                         done_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] cap [0:2047];
    int         cap_n, done_n, busy_n, stab_err;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       clr;
    logic       zero_mode;

    always #5 aclk = ~aclk;

    pmu_dump_sequencer u_dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start_i    (start_i),
        .idle_i     (idle_i),
        .pmu_addr_o (pmu_addr_o),
        .pmu_data_i (pmu_data),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // PMU model with one registered read cycle: byte0 = addr, byte1 = node.
    always @(posedge aclk) begin
        for (int n = 0; n < int'(NODES); n++) begin
            pmu_data[n] <= zero_mode ? '0 : {48'b0, 8'(n), 8'(pmu_addr_o[n])};
        end
    end

    // Inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge aclk) begin
        if (clr) begin
            cap_n      <= 0;
            done_n     <= 0;
            busy_n     <= 0;
            stab_err   <= 0;
            prev_stall <= 1'b0;
            prev_data  <= '0;
        end else begin
            if (aresetn && m_valid_o && m_ready_i) begin
                if (cap_n < 2048) cap[cap_n] <= m_data_o;
                cap_n <= cap_n + 1;
            end
            if (prev_stall && (!m_valid_o || m_data_o != prev_data)) stab_err <= stab_err + 1;
            prev_stall <= aresetn && m_valid_o && !m_ready_i;
            prev_data  <= m_data_o;
            if (done_o) done_n <= done_n + 1;
            if (busy_o) busy_n <= busy_n + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input bit zero);
        int j, w, b;
        if (i == 0) return 8'hA5;
        j = i - 1;
        w = j / 8;
        b = j % 8;
        if (zero) return 8'h00;
        if (b == 0) return 8'(w % 8);
        if (b == 1) return 8'(w / 8);
        return 8'h00;
    endfunction

    task automatic compare_frame(input string tag, input bit zero);
        int         errs;
        logic [7:0] x;
        logic [7:0] e;
        errs = 0;
        x    = 8'h00;
        check_eq({tag, "_len"}, 64'(cap_n), 64'(EXP_LEN));
        for (int i = 0; i < int'(EXP_LEN); i++) begin
            e = (i == 1025) ? x : exp_byte(i, zero);
            if (i >= cap_n || cap[i] !== e) errs++;
            x = x ^ e;
        end
        check_eq({tag, "_bytes"}, 64'(errs), 64'd0);
    endtask

    task automatic run_frame(input bit rnd, input int restart_at, output bit ok);
        bit restarted;
        int budget;
        restarted = 1'b0;
        ok        = 1'b0;
        budget    = int'(frame_bytes(NODES, 8, DW)) * 20;
        @(posedge aclk); #1;
        clr = 1'b1; start_i = 1'b1; m_ready_i = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(posedge aclk); #1;
            clr     = 1'b0;
            start_i = 1'b0;
            m_ready_i = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (restart_at >= 0 && !restarted && cap_n >= restart_at) begin
                start_i   = 1'b1;
                restarted = 1'b1;
            end
            if (done_n != 0) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready_i = 1'b1;
        start_i   = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(m_valid_o), 64'd0);
        check_eq({tag, "_data"},  64'(m_data_o),  64'd0);
        check_eq({tag, "_busy"},  64'(busy_o),    64'd0);
        check_eq({tag, "_done"},  64'(done_o),    64'd0);
        check_eq({tag, "_addr"},  64'(|pmu_addr_o), 64'd0);
    endtask

    initial begin
        bit ok;
        int vhi;
        aresetn   = 1'b0;
        start_i   = 1'b0;
        idle_i    = '1;
        m_ready_i = 1'b1;
        clr       = 1'b1;
        zero_mode = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("por");
        @(negedge aclk);
        aresetn = 1'b1;

        // Full rate, pattern data.
        run_frame(1'b0, -1, ok);
        check_eq("full_done_seen", 64'(ok), 64'd1);
        compare_frame("full", 1'b0);
        check_eq("full_hdr",   64'(cap[0]),  64'hA5);
        check_eq("full_b1",    64'(cap[1]),  64'h00);
        check_eq("full_b2",    64'(cap[2]),  64'h00);
        check_eq("full_n0a1",  64'(cap[9]),  64'h01);
        check_eq("full_n1a0",  64'(cap[66]), 64'h01);
        check_eq("full_done_n", 64'(done_n), 64'd1);
        check_eq("full_busy_cycles", 64'(busy_n), 64'(EXP_BUSY));
        check_eq("full_end_valid", 64'(m_valid_o), 64'd0);

        // Node 7 not idle for 50 cycles after start.
        idle_i[7] = 1'b0;
        @(posedge aclk); #1;
        clr = 1'b1; start_i = 1'b1;
        @(posedge aclk); #1;
        clr = 1'b0; start_i = 1'b0;
        vhi = 0;
        repeat (50) begin
            @(posedge aclk); #1;
            if (m_valid_o) vhi++;
        end
        check_eq("idle_hold_valid", 64'(vhi), 64'd0);
        check_eq("idle_hold_busy", 64'(busy_o), 64'd1);
        idle_i[7] = 1'b1;
        @(posedge aclk); #1;
        check_eq("idle_hdr_valid", 64'(m_valid_o), 64'd1);
        check_eq("idle_hdr_data",  64'(m_data_o),  64'hA5);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge aclk); #1;
            if (done_n != 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(posedge aclk);
        #1;
        check_eq("idle_done_seen", 64'(ok), 64'd1);
        compare_frame("idle", 1'b0);

        // 30% ready duty.
        run_frame(1'b1, -1, ok);
        check_eq("rand_done_seen", 64'(ok), 64'd1);
        compare_frame("rand", 1'b0);
        check_eq("rand_stable", 64'(stab_err), 64'd0);
        check_eq("rand_done_n", 64'(done_n), 64'd1);

        // Second start while busy must be ignored.
        run_frame(1'b0, 200, ok);
        check_eq("restart_done_seen", 64'(ok), 64'd1);
        compare_frame("restart", 1'b0);
        check_eq("restart_done_n", 64'(done_n), 64'd1);
        check_eq("restart_busy_cycles", 64'(busy_n), 64'(EXP_BUSY));

        // Asynchronous reset at byte 500.
        @(posedge aclk); #1;
        clr = 1'b1; start_i = 1'b1;
        @(posedge aclk); #1;
        clr = 1'b0; start_i = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge aclk); #1;
            if (cap_n >= 500) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("rst_reached_500", 64'(ok), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge aclk);
        #1;
        check_reset_outputs("midrst_hold");
        @(negedge aclk);
        aresetn = 1'b1;
        run_frame(1'b0, -1, ok);
        check_eq("after_rst_done_seen", 64'(ok), 64'd1);
        compare_frame("after_rst", 1'b0);
        check_eq("after_rst_done_n", 64'(done_n), 64'd1);

        // All-zero counters.
        zero_mode = 1'b1;
        run_frame(1'b0, -1, ok);
        check_eq("zero_done_seen", 64'(ok), 64'd1);
        compare_frame("zero", 1'b1);
        check_eq("zero_last", 64'(cap[EXP_LEN-1]), 64'(EXP_ZERO_LAST));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
